// File: rtl/native2axis.sv
// native2axis: native video timing stream -> AXI4-Stream video bridge.
// A one-deep capture stage feeds a single-clock FIFO whose head sits in a
// registered output (first-word fall-through). tuser marks start of frame,
// tlast marks end of line.
// Optional feature macro: NATIVE2AXIS_LINE_CHECK_EN. When defined, a
// saturating pixel counter checks every line length against natv_ppl.
// When undefined, line_err is tied low and natv_ppl is ignored.
module native2axis #(
  parameter int DWID     = 24,
  parameter int BUF_AWID = 10,
  parameter int PPL_WID  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DWID-1:0]    natv_data,
  input  logic               natv_active,
  input  logic               natv_hblank,
  input  logic               natv_vblank,
  input  logic [PPL_WID-1:0] natv_ppl,
  output logic [DWID-1:0]    axis_tdata,
  output logic               axis_tvalid,
  input  logic               axis_tready,
  output logic               axis_tuser,
  output logic               axis_tlast,
  input  logic               ovf_clr,
  output logic               ovf,
  output logic               line_err
);

  localparam int DEPTH = 1 << BUF_AWID;
  localparam int CW    = BUF_AWID + 1;
  localparam int WW    = DWID + 2;

  typedef enum logic [1:0] {ST_SYNC, ST_RUN, ST_DROP} state_e;

  state_e              state_q;
  logic                ovf_q;
  logic                vb_seen_q;
  logic                pix_vld_q;
  logic                pix_sof_q;
  logic [DWID-1:0]     pix_data_q;
  logic [WW-1:0]       mem_q [DEPTH];
  logic [BUF_AWID-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d, mem_cnt;
  logic [WW-1:0]       out_q;
  logic                tvalid_q;

  logic          full, wr_req, push, wr_drop, wr_last, pop;
  logic          load_out, rd_mem, bypass, wr_mem;
  logic [WW-1:0] wr_word;

  // Blanking level is implied by natv_active; hblank carries no extra information.
  logic unused_hblank;
  assign unused_hblank = natv_hblank;

  // Write request from the capture stage; tlast is known one cycle after capture.
  assign full     = (count_q == CW'(DEPTH));
  assign wr_req   = pix_vld_q && ((state_q == ST_RUN) || pix_sof_q);
  assign push     = wr_req && !full;
  assign wr_drop  = wr_req && full;
  assign wr_last  = !natv_active;
  assign wr_word  = {pix_sof_q, wr_last, pix_data_q};
  assign pop      = tvalid_q && axis_tready;
  assign mem_cnt  = count_q - {{BUF_AWID{1'b0}}, tvalid_q};
  // Output register refills from RAM when it holds the oldest data, otherwise
  // an incoming word bypasses straight into it.
  assign load_out = !tvalid_q || pop;
  assign rd_mem   = load_out && (mem_cnt != '0);
  assign bypass   = load_out && (mem_cnt == '0) && push;
  assign wr_mem   = push && !bypass;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // Capture stage and start-of-frame tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vb_seen_q  <= 1'b0;
      pix_vld_q  <= 1'b0;
      pix_sof_q  <= 1'b0;
      pix_data_q <= '0;
    end else begin
      pix_vld_q <= natv_active;
      pix_sof_q <= vb_seen_q;
      if (natv_active) begin
        pix_data_q <= natv_data;
        vb_seen_q  <= 1'b0;
      end else if (natv_vblank) begin
        vb_seen_q <= 1'b1;
      end
    end
  end

  // Frame lock FSM with the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN:  if (wr_drop) state_q <= ST_DROP;
        default: if (pix_vld_q && pix_sof_q && !full) state_q <= ST_RUN;
      endcase
      if (wr_drop)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // FIFO storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_mem) mem_q[wr_ptr_q] <= wr_word;
  end

  // FIFO pointers and total occupancy (RAM plus output register).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_mem) wr_ptr_q <= wr_ptr_q + BUF_AWID'(1);
      if (rd_mem) rd_ptr_q <= rd_ptr_q + BUF_AWID'(1);
      count_q <= count_d;
    end
  end

  // Registered read into the AXI output register; held while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      tvalid_q <= 1'b0;
    end else if (load_out) begin
      if (rd_mem)      out_q <= mem_q[rd_ptr_q];
      else if (bypass) out_q <= wr_word;
      tvalid_q <= rd_mem || bypass;
    end
  end

  assign axis_tdata  = out_q[DWID-1:0];
  assign axis_tlast  = out_q[DWID];
  assign axis_tuser  = out_q[DWID+1];
  assign axis_tvalid = tvalid_q;
  assign ovf         = ovf_q;

`ifdef NATIVE2AXIS_LINE_CHECK_EN
  logic [PPL_WID-1:0] pix_cnt_q, cnt_base;
  logic [PPL_WID:0]   cnt_inc;
  logic               line_err_q;

  // An SOF pixel always starts a fresh line count.
  assign cnt_base = pix_sof_q ? '0 : pix_cnt_q;
  assign cnt_inc  = {1'b0, cnt_base} + {{PPL_WID{1'b0}}, 1'b1};

  // Saturating per-line pixel counter; length checked only while locked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt_q  <= '0;
      line_err_q <= 1'b0;
    end else begin
      line_err_q <= 1'b0;
      if (push) begin
        if (wr_last) begin
          pix_cnt_q <= '0;
          if ((state_q == ST_RUN) && (cnt_inc != {1'b0, natv_ppl})) line_err_q <= 1'b1;
        end else begin
          pix_cnt_q <= (&cnt_base) ? cnt_base : cnt_inc[PPL_WID-1:0];
        end
      end
    end
  end

  assign line_err = line_err_q;
`else
  logic unused_ppl;
  assign unused_ppl = ^natv_ppl;
  assign line_err   = 1'b0;
`endif

endmodule

// File: tb/tb_native2axis.sv
// Testbench for native2axis: directed frame scenarios with randomized data
// and backpressure, checked every cycle against a queue-based model.
module tb_native2axis;
  localparam int DWID  = 24;
  localparam int AWID  = 2;
  localparam int PW    = 12;
  localparam int DEPTH = 1 << AWID;
`ifdef NATIVE2AXIS_LINE_CHECK_EN
  localparam int EXP_LERR = 1;
`else
  localparam int EXP_LERR = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [DWID-1:0] natv_data;
  logic            natv_active, natv_hblank, natv_vblank;
  logic [PW-1:0]   natv_ppl;
  logic [DWID-1:0] axis_tdata;
  logic            axis_tvalid, axis_tready, axis_tuser, axis_tlast;
  logic            ovf_clr, ovf, line_err;

  always #5 clk = ~clk;

  native2axis #(.DWID(DWID), .BUF_AWID(AWID), .PPL_WID(PW)) dut (
    .clk(clk), .rst_n(rst_n), .natv_data(natv_data), .natv_active(natv_active),
    .natv_hblank(natv_hblank), .natv_vblank(natv_vblank), .natv_ppl(natv_ppl),
    .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
    .axis_tuser(axis_tuser), .axis_tlast(axis_tlast), .ovf_clr(ovf_clr),
    .ovf(ovf), .line_err(line_err)
  );

  typedef struct {
    logic [DWID-1:0] d;
    bit              sof;
    bit              last;
  } beat_t;

  // Reference model: queue of beats the sink should see, plus frame lock.
  beat_t           q[$];
  bit              m_locked, m_vb, m_ovf, m_lerr, p_valid, p_sof, armed;
  logic [DWID-1:0] p_data;
  int              line_len;

  int              checks = 0, failures = 0;
  int              obs_beats = 0, lerr_pulses = 0;
  bit              g_rst, g_clr;
  int              g_rdy_mode;
  logic [PW-1:0]   g_ppl;
  logic [DWID-1:0] g_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit act, input bit hb, input bit vb, input logic [DWID-1:0] d);
    bit    rdy, full, do_pop, set_ovf, new_lerr, was;
    beat_t b;
    @(negedge clk);
    if (armed) begin
      chk("tvalid", 32'(axis_tvalid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("tdata", 32'(axis_tdata), 32'(q[0].d));
        chk("tuser", 32'(axis_tuser), 32'(q[0].sof));
        chk("tlast", 32'(axis_tlast), 32'(q[0].last));
      end
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("line_err", 32'(line_err), 32'(m_lerr));
      if (line_err === 1'b1) lerr_pulses++;
    end
    rdy = (g_rdy_mode == 2) ? ($urandom_range(3) != 0) : (g_rdy_mode == 1);
    rst_n       = !g_rst;
    natv_active = act;
    natv_hblank = hb;
    natv_vblank = vb;
    natv_data   = d;
    axis_tready = rdy;
    ovf_clr     = g_clr;
    natv_ppl    = g_ppl;
    if (!g_rst && axis_tvalid === 1'b1 && rdy) obs_beats++;
    if (g_rst) begin
      q.delete();
      m_locked = 0; m_vb = 0; m_ovf = 0; m_lerr = 0;
      p_valid = 0; p_sof = 0; p_data = '0; line_len = 0;
      armed = 1;
    end else begin
      full     = (q.size() == DEPTH);
      do_pop   = (q.size() > 0) && rdy;
      set_ovf  = 0;
      new_lerr = 0;
      if (p_valid && (m_locked || p_sof)) begin
        if (full) begin
          set_ovf  = 1;
          m_locked = 0;
        end else begin
          was    = m_locked;
          b.d    = p_data;
          b.sof  = p_sof;
          b.last = !act;
          line_len = p_sof ? 1 : line_len + 1;
          if (b.last) begin
            if (was && line_len != int'(g_ppl)) new_lerr = 1;
            line_len = 0;
          end
          m_locked = 1;
          q.push_back(b);
        end
      end
      if (set_ovf) m_ovf = 1;
      else if (g_clr) m_ovf = 0;
      m_lerr = (EXP_LERR != 0) ? new_lerr : 1'b0;
      if (do_pop) b = q.pop_front();
      p_valid = act;
      p_data  = d;
      p_sof   = m_vb;
      if (act) m_vb = 0;
      else if (vb) m_vb = 1;
    end
  endtask

  task automatic blank(input int n, input bit vb);
    repeat (n) tick(1'b0, 1'b1, vb, '0);
  endtask

  task automatic line(input int npix, input bit rnd);
    for (int i = 0; i < npix; i++) begin
      tick(1'b1, 1'b0, 1'b0, rnd ? DWID'($urandom) : g_data);
      g_data = g_data + 1'b1;
    end
  endtask

  initial begin
    int b0, p0;
    rst_n = 1'b0; natv_active = 1'b0; natv_hblank = 1'b1; natv_vblank = 1'b0;
    natv_data = '0; natv_ppl = 12'd4; axis_tready = 1'b0; ovf_clr = 1'b0;
    armed = 0; g_rst = 1; g_clr = 0; g_rdy_mode = 1; g_ppl = 12'd4; g_data = 24'd1;

    // Reset state
    blank(3, 0);
    g_rst = 0;
    blank(1, 0);
    chk("rst_tvalid", 32'(axis_tvalid), 0);
    chk("rst_tdata", 32'(axis_tdata), 0);
    chk("rst_tuser", 32'(axis_tuser), 0);
    chk("rst_tlast", 32'(axis_tlast), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_line_err", 32'(line_err), 0);

    // 4x2 frame, data 1..8, tready=1, latency 2
    b0 = obs_beats; p0 = lerr_pulses;
    blank(2, 1);
    tick(1'b1, 1'b0, 1'b0, 24'd1);
    tick(1'b1, 1'b0, 1'b0, 24'd2);
    chk("s1_lat_c1", 32'(axis_tvalid), 0);
    tick(1'b1, 1'b0, 1'b0, 24'd3);
    chk("s1_lat_c2", 32'(axis_tvalid), 1);
    tick(1'b1, 1'b0, 1'b0, 24'd4);
    blank(3, 0);
    g_data = 24'd5;
    line(4, 0);
    blank(4, 0);
    chk("s1_beats", 32'(obs_beats - b0), 8);
    chk("s1_no_lerr", 32'(lerr_pulses - p0), 0);

    // Reset released mid-frame: rest of frame discarded
    blank(2, 1);
    line(4, 0);
    blank(1, 0);
    g_rst = 1;
    blank(2, 0);
    g_rst = 0;
    b0 = obs_beats;
    line(4, 0);
    blank(3, 0);
    line(4, 0);
    blank(3, 0);
    chk("s2_no_beats", 32'(obs_beats - b0), 0);
    b0 = obs_beats;
    blank(2, 1);
    line(4, 0);
    blank(3, 0);
    line(4, 0);
    blank(4, 0);
    chk("s2_next_frame", 32'(obs_beats - b0), 8);

    // Overflow with tready=0, then drain and recover
    g_rdy_mode = 0;
    blank(2, 1);
    line(8, 0);
    blank(3, 0);
    chk("s3_ovf_set", 32'(ovf), 1);
    chk("s3_held_valid", 32'(axis_tvalid), 1);
    g_rdy_mode = 1;
    b0 = obs_beats;
    blank(6, 0);
    chk("s3_drained", 32'(obs_beats - b0), 4);
    b0 = obs_beats;
    blank(2, 1);
    line(4, 0);
    blank(4, 0);
    chk("s3_next_frame", 32'(obs_beats - b0), 4);
    chk("s3_ovf_sticky", 32'(ovf), 1);
    g_clr = 1;
    blank(1, 0);
    g_clr = 0;
    blank(1, 0);
    chk("s3_ovf_clr", 32'(ovf), 0);

    // Short line against natv_ppl=4
    p0 = lerr_pulses;
    blank(2, 1);
    line(3, 0);
    blank(3, 0);
    line(4, 0);
    blank(4, 0);
    chk("s4_lerr_pulses", 32'(lerr_pulses - p0), 32'(EXP_LERR));

    // Random data and backpressure over 16-pixel frames
    g_rdy_mode = 2;
    repeat (3) begin
      blank(2, 1);
      repeat (4) begin
        line(4, 1);
        blank($urandom_range(3, 1), 0);
      end
    end
    g_rdy_mode = 1;
    blank(8, 0);
    g_clr = 1;
    blank(1, 0);
    g_clr = 0;

    // Reset with 3 beats queued: no stale beats afterwards
    g_rdy_mode = 0;
    blank(2, 1);
    line(3, 0);
    blank(3, 0);
    chk("s6_queued", 32'(axis_tvalid), 1);
    g_rst = 1;
    blank(1, 0);
    g_rst = 0;
    blank(1, 0);
    chk("s6_tvalid_clr", 32'(axis_tvalid), 0);
    g_rdy_mode = 1;
    b0 = obs_beats;
    blank(5, 0);
    line(4, 0);
    blank(4, 0);
    chk("s6_no_stale", 32'(obs_beats - b0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/native2axis.md
Name: native2axis

Overview:
- Video capture bridge: converts a free-running native video stream (data/active/hblank/vblank timing, cannot be stalled) into an AXI4-Stream video stream.
- Marks start-of-frame with tuser and end-of-line with tlast.
- Buffers pixels in an internal single-clock FIFO to absorb downstream backpressure.
- Sits between the capture front end / timing decoder and the AXI-stream video pipeline; it is the reverse direction of axis2native.

Parameters:
- DWID, 24, pixel data width.
- BUF_AWID, 10, FIFO address width; depth = 2^BUF_AWID entries of DWID+2 bits.
- PPL_WID, 12, width of the pixel counter and of natv_ppl.

Ports:
- clk  in  1  single clock; native and AXI sides share it.
- rst_n  in  1  synchronous reset, active-low.
- natv_data  in  DWID  pixel data, valid when natv_active=1.
- natv_active  in  1  active-video pixel strobe.
- natv_hblank  in  1  horizontal blanking.
- natv_vblank  in  1  vertical blanking.
- natv_ppl  in  PPL_WID  expected pixels per line.
- axis_tdata  out  DWID  pixel data.
- axis_tvalid  out  1  beat valid.
- axis_tready  in  1  downstream ready.
- axis_tuser  out  1  first pixel of frame.
- axis_tlast  out  1  last pixel of line.
- ovf_clr  in  1  clears ovf.
- ovf  out  1  sticky overflow flag.
- line_err  out  1  one-cycle pulse when a line length does not equal natv_ppl.

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO emptied; FSM=SYNC; vb_seen=0; pixel stage cleared. axis_tvalid, axis_tuser, axis_tlast, axis_tdata, ovf and line_err are all 0 from the following cycle.
- SOF tagging:
  - vb_seen is set on any cycle with natv_vblank=1.
  - vb_seen is cleared when an active pixel is captured.
  - A captured pixel with vb_seen=1 is SOF; it carries tuser=1.
- Capture stage:
  - An active pixel in cycle N is registered at the end of cycle N.
  - In cycle N+1 it is written to the FIFO with tlast = !natv_active in cycle N+1.
  - With the FIFO empty, that beat has axis_tvalid=1 in cycle N+2. Latency is 2 cycles.
- FSM:
  - SYNC: staged pixels are discarded until an SOF pixel arrives; that SOF pixel is written; go to RUN.
  - RUN: every staged pixel is written. A write attempted while full is not performed; set ovf; go to DROP.
  - DROP: discard everything until the next SOF pixel; that pixel is written if not full (then go to RUN), otherwise stay in DROP.
- FIFO:
  - Full means count == 2^BUF_AWID, evaluated on the current count.
  - A write at full is dropped even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
  - Empty: axis_tvalid=0.
- AXI rules:
  - tvalid, once high, stays high until the tready handshake.
  - tdata, tuser and tlast are stable while tvalid=1 and tready=0.
  - A beat pops when tvalid && tready.
  - Read is first-word fall-through from a registered output.
- ovf: set on a dropped write; cleared by ovf_clr=1. Set has priority over clear in the same cycle.
- Pixel counter (PPL_WID bits, saturating):
  - Counts written pixels of the current line; resets to 0 after each tlast write.
  - On a tlast write, if count+1 != natv_ppl, line_err pulses in the next cycle.
  - No check in SYNC or DROP.
- Reset mid-frame: the frame is abandoned; output resumes at the next SOF.

Optional Feature:
- NATIVE2AXIS_LINE_CHECK_EN
  - Defined: pixel counter and line_err logic as described above.
  - Undefined: counter not built; line_err tied to 0; natv_ppl unused. All other behaviour is identical.

Test Plan:
- 4x2 frame (vblank, then two 4-pixel lines, data 1..8), natv_ppl=4, tready=1 -> 8 beats; beat 1 has tuser=1; beats 4 and 8 have tlast=1; first tvalid 2 cycles after the first active pixel; line_err never pulses.
- Release reset mid-frame (line 2 of frame) -> no beats until the next frame; that frame's first beat has tuser=1.
- BUF_AWID=2, tready=0, one 8-pixel line after vblank -> 4 beats buffered; ovf=1 on the 5th write; pixels 5-8 dropped. Then tready=1 -> 4 beats drained; next frame delivered intact; ovf stays 1 until ovf_clr.
- 3-pixel line with natv_ppl=4 -> tlast on the 3rd beat; line_err=1 for exactly one cycle after that write.
- tready toggled 1,0,0,1 pseudo-randomly over a 16-pixel frame -> no loss, order preserved; tdata/tuser/tlast held stable while stalled.
- rst_n=0 while 3 beats are queued -> tvalid=0 the next cycle; no stale beats after reset release.
